// File: rtl/jtgng_sndlatch_fifo.sv
// Main-to-sound command FIFO with sound CPU interrupt generation.
// Buffers up to 2**AW commands written by the main CPU. The sound CPU reads the
// head entry, which is popped when its read strobe is released. INT_n is raised
// by a sound tick rising edge and, optionally, by command arrival. It is released
// by a Z80 IORQ acknowledge.
module jtgng_sndlatch_fifo #(
    parameter int DW          = 8,
    parameter int AW          = 2,
    parameter int OVERWRITE   = 0,
    parameter int INT_ON_DATA = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          main_cen,
    input  logic          main_we,
    input  logic [DW-1:0] main_din,
    input  logic          snd_cen,
    input  logic          snd_rd,
    input  logic          snd_tick,
    input  logic          iorq_n,
    output logic [DW-1:0] snd_dout,
    output logic          int_n,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          clr_ovf
);

    localparam int         DEPTH    = 1 << AW;
    // AW=0 still needs a 1-bit pointer; it is held at zero so only entry 0 is used
    localparam int         PW       = (AW > 0) ? AW : 1;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam bit         DATA_INT = (INT_ON_DATA != 0);
    localparam bit         OVW      = (OVERWRITE != 0);

    logic [DW-1:0] mem [0:(1<<PW)-1];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          rd_l;
    logic          tick_l;
    logic          empty_l;

    logic          push;
    logic          pop;
    logic          push_ok;
    logic          push_full;
    logic          int_set;
    logic [AW:0]   level_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (AW == 0) return '0;
        return p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        if (AW == 0) return '0;
        return p - 1'b1;
    endfunction

    assign push      = main_cen & main_we;
    // Pop on the release of the read strobe so data is stable for the whole read
    assign pop       = snd_cen & rd_l & ~snd_rd & ~empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO is accepted
    assign push_ok   = push & (~full | pop);
    assign push_full = push & full & ~pop;
    assign int_set   = (snd_tick & ~tick_l) | (DATA_INT & empty_l & ~empty);

    // Next occupancy from the accepted push and pop of this edge
    always_comb begin
        level_nxt = level;
        if (push_ok && !pop) begin
            level_nxt = level + 1'b1;
        end else if (pop && !push_ok) begin
            level_nxt = level - 1'b1;
        end
    end

    // Command storage; contents need no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= main_din;
        end else if (push_full && OVW) begin
            mem[ptr_dec(wr_ptr)] <= main_din;
        end
    end

    // Pointers, occupancy flags and sticky overflow
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            level <= level_nxt;
            empty <= (level_nxt == '0);
            full  <= (level_nxt == FULL_LVL);
            if (push_full) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Head data register; holds the last command while empty, like the old latch
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            snd_dout <= '0;
        end else if (!empty) begin
            snd_dout <= mem[rd_ptr];
        end
    end

    // Sound-side sampling and interrupt request; acknowledge beats a new set
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_l    <= 1'b0;
            tick_l  <= 1'b0;
            empty_l <= 1'b1;
            int_n   <= 1'b1;
        end else if (snd_cen) begin
            rd_l    <= snd_rd;
            tick_l  <= snd_tick;
            empty_l <= empty;
            if (!iorq_n) begin
                int_n <= 1'b1;
            end else if (int_set) begin
                int_n <= 1'b0;
            end
        end
    end

endmodule
